// File: rtl/mem_pkg.sv
// Shared types, opcodes and access-size decode for the MEM-stage load/store unit.
package mem_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;
  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_LB  = 6'h20;
  localparam logic [OP_W-1:0] OP_LH  = 6'h21;
  localparam logic [OP_W-1:0] OP_LW  = 6'h23;
  localparam logic [OP_W-1:0] OP_LBU = 6'h24;
  localparam logic [OP_W-1:0] OP_LHU = 6'h25;
  localparam logic [OP_W-1:0] OP_SB  = 6'h28;
  localparam logic [OP_W-1:0] OP_SH  = 6'h29;
  localparam logic [OP_W-1:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} mem_state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_t;

  typedef struct packed {
    mem_size_t size;
    logic      sign;
  } mem_dec_t;

  // Opcode to access width and load sign; unknown opcodes are word accesses.
  function automatic mem_dec_t decode_op(input logic [OP_W-1:0] op);
    mem_dec_t d;
    d.size = SZ_W;
    d.sign = 1'b0;
    case (op)
      OP_LB:         begin d.size = SZ_B; d.sign = 1'b1; end
      OP_LBU, OP_SB: d.size = SZ_B;
      OP_LH:         begin d.size = SZ_H; d.sign = 1'b1; end
      OP_LHU, OP_SH: d.size = SZ_H;
      OP_LW, OP_SW:  d.size = SZ_W;
      default:       d.size = SZ_W;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/m_mem_lane_align.sv
// Combinational byte-lane packing for stores and lane extraction/extension for loads.
module m_mem_lane_align
  import mem_pkg::*;
(
  input  mem_size_t        i_st_size,
  input  logic [1:0]       i_st_lo,
  input  logic [XLEN-1:0]  i_st_data,
  output logic [XLEN-1:0]  o_st_wdata,
  output logic [BE_W-1:0]  o_st_be,
  input  mem_size_t        i_ld_size,
  input  logic             i_ld_sign,
  input  logic [1:0]       i_ld_lo,
  input  logic [XLEN-1:0]  i_ld_rdata,
  output logic [XLEN-1:0]  o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Replicate store data into every lane and enable only the addressed bytes.
  always_comb begin
    o_st_wdata = i_st_data;
    o_st_be    = 4'b1111;
    case (i_st_size)
      SZ_B: begin
        o_st_wdata = {4{i_st_data[7:0]}};
        o_st_be    = 4'b0001 << i_st_lo;
      end
      SZ_H: begin
        o_st_wdata = {2{i_st_data[15:0]}};
        o_st_be    = i_st_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Select the addressed lane of the read word and extend it to full width.
  always_comb begin
    w_byte    = 8'(i_ld_rdata >> {i_ld_lo, 3'b000});
    w_half    = i_ld_lo[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
    o_ld_data = i_ld_rdata;
    case (i_ld_size)
      SZ_B:    o_ld_data = {{24{i_ld_sign & w_byte[7]}}, w_byte};
      SZ_H:    o_ld_data = {{16{i_ld_sign & w_half[15]}}, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/m_mem_access_unit.sv
// MEM-stage load/store engine: valid/ready data-memory port, pipeline stall, timeout.
module m_mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  instrM,
  input  logic             memtoregM,
  input  logic             memwriteM,
  input  logic [XLEN-1:0]  aluoutM,
  input  logic [XLEN-1:0]  writedataM,
  output logic             stallM,
  output logic [XLEN-1:0]  readdataM,
  output logic             misalignM,
  output logic             buserrM,
  output logic             dmem_req_valid,
  input  logic             dmem_req_ready,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  output logic [BE_W-1:0]  dmem_be,
  input  logic             dmem_rsp_valid,
  input  logic [XLEN-1:0]  dmem_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  mem_state_t       r_state, w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we, r_sign, r_buserr;
  mem_size_t        r_size;
  logic [XLEN-1:0]  r_addr, r_wdata, r_rdata;
  logic [BE_W-1:0]  r_be;

  mem_dec_t         w_dec;
  logic             w_access, w_misalign, w_cnt_last;
  logic             w_latch, w_cnt_inc, w_rd_load, w_rd_zero, w_timeout;
  logic             w_stall, w_req_valid;
  logic [XLEN-1:0]  w_st_wdata, w_ld_data;
  logic [BE_W-1:0]  w_st_be;
  logic             w_unused_instr;

  assign w_dec          = decode_op(instrM[31:26]);
  assign w_unused_instr = ^instrM[25:0];
  assign w_access       = memtoregM | memwriteM;
  assign w_misalign     = w_access & (((w_dec.size == SZ_W) & (|aluoutM[1:0])) |
                                      ((w_dec.size == SZ_H) & aluoutM[0]));
  assign w_cnt_last     = (r_cnt == CNT_W'(TIMEOUT - 1));

  m_mem_lane_align u_lane (
    .i_st_size  (w_dec.size),
    .i_st_lo    (aluoutM[1:0]),
    .i_st_data  (writedataM),
    .o_st_wdata (w_st_wdata),
    .o_st_be    (w_st_be),
    .i_ld_size  (r_size),
    .i_ld_sign  (r_sign),
    .i_ld_lo    (r_addr[1:0]),
    .i_ld_rdata (dmem_rdata),
    .o_ld_data  (w_ld_data)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state and control decode; a response arriving on the last count beats the timeout.
  always_comb begin
    w_next_state = r_state;
    w_latch      = 1'b0;
    w_cnt_inc    = 1'b0;
    w_rd_load    = 1'b0;
    w_rd_zero    = 1'b0;
    w_timeout    = 1'b0;
    w_stall      = 1'b0;
    w_req_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_misalign) begin
          w_rd_zero = 1'b1;
        end else if (w_access) begin
          w_latch      = 1'b1;
          w_stall      = 1'b1;
          w_next_state = REQ;
        end
      end
      REQ: begin
        w_stall     = 1'b1;
        w_req_valid = 1'b1;
        if (dmem_req_ready && r_we) begin
          w_next_state = DONE;
        end else if (w_cnt_last) begin
          w_timeout    = 1'b1;
          w_rd_zero    = 1'b1;
          w_next_state = DONE;
        end else begin
          w_cnt_inc = 1'b1;
          if (dmem_req_ready) w_next_state = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        w_stall = 1'b1;
        if (dmem_rsp_valid) begin
          w_rd_load    = 1'b1;
          w_next_state = DONE;
        end else if (w_cnt_last) begin
          w_timeout    = 1'b1;
          w_rd_zero    = 1'b1;
          w_next_state = DONE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Latched request fields, timeout counter, load result and bus-error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we     <= 1'b0;
      r_sign   <= 1'b0;
      r_size   <= SZ_W;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_buserr <= 1'b0;
    end else begin
      r_buserr <= w_timeout;
      if (w_latch) begin
        r_we    <= memwriteM;
        r_sign  <= w_dec.sign;
        r_size  <= w_dec.size;
        r_addr  <= aluoutM;
        r_wdata <= w_st_wdata;
        r_be    <= w_st_be;
        r_cnt   <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_rd_zero)      r_rdata <= '0;
      else if (w_rd_load) r_rdata <= w_ld_data;
    end
  end

  assign stallM         = w_stall & ~reset;
  assign misalignM      = w_misalign & ~reset;
  assign buserrM        = r_buserr;
  assign readdataM      = r_rdata;
  assign dmem_req_valid = w_req_valid;
  assign dmem_we        = w_req_valid & r_we;
  assign dmem_addr      = w_req_valid ? {r_addr[31:2], 2'b00} : '0;
  assign dmem_wdata     = w_req_valid ? r_wdata : '0;
  assign dmem_be        = w_req_valid ? r_be : '0;

  logic w_unused_ok;
  assign w_unused_ok = w_unused_instr;

endmodule

// File: tb/tb_m_mem_access_unit.sv
// Self-checking bench for m_mem_access_unit against a transaction-level model.
`timescale 1ns/1ps
module tb_m_mem_access_unit;

  localparam int unsigned T = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instrM, aluoutM, writedataM, readdataM, dmem_addr, dmem_wdata, dmem_rdata;
  logic        memtoregM, memwriteM, stallM, misalignM, buserrM;
  logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
  logic [3:0]  dmem_be;

  m_mem_access_unit #(.TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .instrM(instrM), .memtoregM(memtoregM), .memwriteM(memwriteM),
    .aluoutM(aluoutM), .writedataM(writedataM), .stallM(stallM), .readdataM(readdataM),
    .misalignM(misalignM), .buserrM(buserrM), .dmem_req_valid(dmem_req_valid),
    .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rsp_valid(dmem_rsp_valid),
    .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic        chk_en = 1'b0;
  logic        exp_stall, exp_mis, exp_buserr, exp_valid, exp_we, exp_store;
  logic [31:0] exp_addr, exp_wdata, exp_rd, model_rd;
  logic [3:0]  exp_be;

  int          obs_stall, obs_busy, obs_valid;
  logic        obs_mis, obs_buserr, obs_we;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;

  logic [5:0] ld_ops [6] = '{6'h23, 6'h20, 6'h24, 6'h21, 6'h25, 6'h00};
  logic [5:0] st_ops [4] = '{6'h2B, 6'h28, 6'h29, 6'h3F};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Access width in bytes implied by the opcode.
  function automatic int m_bytes(input logic [5:0] op);
    case (op)
      6'h20, 6'h24, 6'h28: return 1;
      6'h21, 6'h25, 6'h29: return 2;
      default:             return 4;
    endcase
  endfunction

  function automatic bit m_misaligned(input logic [5:0] op, input logic [31:0] a);
    return (int'(a[1:0]) % m_bytes(op)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [5:0] op, input logic [31:0] a);
    int mask;
    mask = ((1 << m_bytes(op)) - 1) << int'(a[1:0]);
    return 4'(mask);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] wd);
    case (m_bytes(op))
      1:       return {4{wd[7:0]}};
      2:       return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    v = w >> (8 * int'(a[1:0]));
    if (m_bytes(op) == 1) begin
      v = v & 32'h0000_00FF;
      if (op == 6'h20 && v[7]) v = v | 32'hFFFF_FF00;
    end else if (m_bytes(op) == 2) begin
      v = v & 32'h0000_FFFF;
      if (op == 6'h21 && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Single compare point: every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stallM", 32'(stallM), 32'(exp_stall));
      chk("misalignM", 32'(misalignM), 32'(exp_mis));
      chk("buserrM", 32'(buserrM), 32'(exp_buserr));
      chk("req_valid", 32'(dmem_req_valid), 32'(exp_valid));
      chk("readdataM", readdataM, exp_rd);
      if (exp_valid) begin
        chk("dmem_we", 32'(dmem_we), 32'(exp_we));
        chk("dmem_addr", dmem_addr, exp_addr);
        if (exp_store) begin
          chk("dmem_be", 32'(dmem_be), 32'(exp_be));
          chk("dmem_wdata", dmem_wdata, exp_wdata);
        end
      end
    end
  end

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      instrM = $urandom; memtoregM = 1'b0; memwriteM = 1'b0;
      aluoutM = $urandom; writedataM = $urandom;
      dmem_req_ready = 1'($urandom); dmem_rsp_valid = 1'($urandom); dmem_rdata = $urandom;
      exp_stall = 1'b0; exp_mis = 1'b0; exp_buserr = 1'b0; exp_valid = 1'b0; exp_rd = model_rd;
      @(negedge clk);
    end
  endtask

  // One instruction held in MEM; R = REQ cycles before ready, S = WAIT cycles before response.
  task automatic run_txn(input logic [5:0] op, input logic st, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int R, input int S);
    int lat, busy, last;
    bit err, mis, in_wait;
    mis  = m_misaligned(op, a);
    lat  = st ? R + 1 : R + S + 2;
    err  = lat > int'(T);
    busy = err ? int'(T) : lat;
    last = mis ? 0 : busy + 1;
    obs_stall = 0; obs_busy = 0; obs_valid = 0; obs_mis = 1'b0; obs_buserr = 1'b0;
    for (int c = 0; c <= last; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        instrM = {op, 26'($urandom)}; memtoregM = !st; memwriteM = st;
        aluoutM = a; writedataM = wd;
      end
      exp_rd     = model_rd;
      exp_mis    = mis;
      exp_stall  = !mis && c <= busy;
      exp_valid  = !mis && c >= 1 && c <= busy && c <= R + 1;
      in_wait    = !mis && !st && c >= R + 2 && c <= busy;
      exp_buserr = !mis && c == busy + 1 && err;
      exp_we     = st; exp_store = st;
      exp_addr   = {a[31:2], 2'b00};
      exp_be     = m_be(op, a);
      exp_wdata  = m_wdata(op, wd);
      dmem_req_ready = exp_valid ? (c == R + 1) : 1'($urandom);
      dmem_rsp_valid = in_wait ? (c == R + 2 + S) : 1'($urandom);
      dmem_rdata     = (in_wait && c == R + 2 + S) ? rd : $urandom;
      if (mis) model_rd = '0;
      else if (c == busy && (err || !st)) model_rd = err ? 32'h0 : m_load(op, a, rd);
      @(negedge clk);
      obs_stall += int'(stallM);
      if (c >= 1 && stallM) obs_busy++;
      if (dmem_req_valid) begin
        obs_valid++;
        obs_we = dmem_we; obs_addr = dmem_addr; obs_be = dmem_be; obs_wdata = dmem_wdata;
      end
      obs_mis    = obs_mis | misalignM;
      obs_buserr = obs_buserr | buserrM;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0]  op;
    logic [31:0] a;
    logic        st;
    int          R, S;

    reset = 1'b1; instrM = '0; memtoregM = 1'b0; memwriteM = 1'b0; aluoutM = '0; writedataM = '0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;
    model_rd = '0; exp_rd = '0; exp_stall = 1'b0; exp_mis = 1'b0; exp_buserr = 1'b0;
    exp_valid = 1'b0; exp_we = 1'b0; exp_store = 1'b0; exp_addr = '0; exp_be = '0; exp_wdata = '0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_dmem_addr", dmem_addr, 32'h0);
    chk("rst_dmem_be", 32'(dmem_be), 32'h0);
    chk("rst_dmem_we", 32'(dmem_we), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_idle(2);

    // Word store, ready immediately.
    run_txn(6'h2B, 1'b1, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
    chk("t1_stall_cycles", 32'(obs_stall), 32'd2);
    chk("t1_req_count", 32'(obs_valid), 32'd1);
    chk("t1_we", 32'(obs_we), 32'd1);
    chk("t1_addr", obs_addr, 32'h100);
    chk("t1_be", 32'(obs_be), 32'hF);
    chk("t1_wdata", obs_wdata, 32'hDEADBEEF);

    // Byte loads, signed and unsigned.
    run_txn(6'h20, 1'b0, 32'h203, 32'h0, 32'h80FF7F01, 0, 0);
    chk("t2_lb", readdataM, 32'hFFFFFF80);
    chk("t2_stall_cycles", 32'(obs_stall), 32'd3);
    run_txn(6'h24, 1'b0, 32'h203, 32'h0, 32'h80FF7F01, 1, 2);
    chk("t2_lbu", readdataM, 32'h00000080);

    // Halfword store and signed load on the upper half.
    run_txn(6'h29, 1'b1, 32'h42, 32'h0000A55A, 32'h0, 2, 0);
    chk("t3_be", 32'(obs_be), 32'hC);
    chk("t3_wdata", obs_wdata, 32'hA55AA55A);
    run_txn(6'h21, 1'b0, 32'h42, 32'h0, 32'h9ABC0000, 0, 1);
    chk("t3_lh", readdataM, 32'hFFFF9ABC);

    // Misaligned word load: no request, no stall, result cleared.
    run_txn(6'h23, 1'b0, 32'h101, 32'h0, 32'h0, 0, 0);
    chk("t4_misalign", 32'(obs_mis), 32'd1);
    chk("t4_req_count", 32'(obs_valid), 32'd0);
    chk("t4_stall_cycles", 32'(obs_stall), 32'd0);
    run_idle(1);
    chk("t4_rd_cleared", readdataM, 32'h0);

    // Good load, then a load whose response never comes.
    run_txn(6'h23, 1'b0, 32'h104, 32'h0, 32'hCAFEF00D, 0, 0);
    chk("t5_pre_lw", readdataM, 32'hCAFEF00D);
    run_txn(6'h23, 1'b0, 32'h400, 32'h0, 32'h11111111, 0, 100);
    chk("t5_busy_cycles", 32'(obs_busy), 32'd16);
    chk("t5_buserr", 32'(obs_buserr), 32'd1);
    chk("t5_rd_zero", readdataM, 32'h0);
    run_idle(1);
    chk("t5_buserr_pulse", 32'(buserrM), 32'd0);

    // Timeout boundaries: completing on the last counted cycle is not an error.
    run_txn(6'h2B, 1'b1, 32'h500, 32'h01020304, 32'h0, 15, 0);
    chk("bnd_st15_err", 32'(obs_buserr), 32'd0);
    run_txn(6'h2B, 1'b1, 32'h504, 32'h01020304, 32'h0, 16, 0);
    chk("bnd_st16_err", 32'(obs_buserr), 32'd1);
    run_txn(6'h23, 1'b0, 32'h508, 32'h0, 32'h55AA33CC, 3, 11);
    chk("bnd_ld16_err", 32'(obs_buserr), 32'd0);
    chk("bnd_ld16_rd", readdataM, 32'h55AA33CC);
    run_txn(6'h23, 1'b0, 32'h50C, 32'h0, 32'h55AA33CC, 3, 12);
    chk("bnd_ld17_err", 32'(obs_buserr), 32'd1);

    // Reset while waiting for a response; the late response must be ignored.
    run_txn(6'h23, 1'b0, 32'h300, 32'h0, 32'h12345678, 0, 0);
    chk("t6_pre", readdataM, 32'h12345678);
    @(posedge clk); #1;
    instrM = {6'h23, 26'h0}; memtoregM = 1'b1; memwriteM = 1'b0; aluoutM = 32'h304;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    exp_rd = model_rd; exp_stall = 1'b1; exp_valid = 1'b0; exp_mis = 1'b0; exp_buserr = 1'b0;
    @(posedge clk); #1;
    dmem_req_ready = 1'b1;
    exp_valid = 1'b1; exp_we = 1'b0; exp_store = 1'b0; exp_addr = 32'h304;
    @(posedge clk); #1;
    dmem_req_ready = 1'b0; exp_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_rd = '0; exp_rd = '0; exp_stall = 1'b0;
    @(negedge clk);
    chk("t6_rst_addr", dmem_addr, 32'h0);
    chk("t6_rst_stall", 32'(stallM), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; memtoregM = 1'b0; dmem_rsp_valid = 1'b1; dmem_rdata = 32'hFEEDFACE;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_rd_kept", readdataM, 32'h0);
    chk("t6_no_stall", 32'(stallM), 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      st = 1'($urandom);
      op = st ? st_ops[$urandom_range(0, 3)] : ld_ops[$urandom_range(0, 5)];
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(m_bytes(op) - 1);
      R  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 3);
      S  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 3);
      run_txn(op, st, a, $urandom, $urandom, R, S);
      run_idle($urandom_range(0, 2));
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
